// File: rtl/life_ctrl_4x4.sv
// Sequencer for the 4x4 life array: loads a 16-cell seed one cell per clock,
// then issues run pulses at a programmable period for a programmable number
// of generations, and reports completion.
//
// Ports:
//   clk, reset      - clock; synchronous active-low reset
//   start, stop     - begin load-then-run (IDLE only); abort LOAD/RUN
//   pattern         - seed, bit i -> col=i[3:2], row=i[1:0]
//   num_gens        - generations to run, 0 = until stop
//   period          - clocks between run pulses, 0 treated as 1
//   row, col, val   - array write address/data
//   write_enb, run  - array write strobe and generation-advance pulse
//   busy, done      - high in LOAD/RUN; one-cycle completion pulse
//   gen_count       - run pulses issued since the last start
module life_ctrl_4x4 #(
    parameter int unsigned GEN_W = 8,
    parameter int unsigned PER_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic [15:0]      pattern,
    input  logic [GEN_W-1:0] num_gens,
    input  logic [PER_W-1:0] period,
    output logic [1:0]       row,
    output logic [1:0]       col,
    output logic             val,
    output logic             write_enb,
    output logic             run,
    output logic             busy,
    output logic             done,
    output logic [GEN_W-1:0] gen_count
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_e;

    state_e           state_q, state_d;
    logic [3:0]       idx_q, idx_d;
    logic [PER_W-1:0] div_q, div_d;
    logic [15:0]      pat_q, pat_d;
    logic [GEN_W-1:0] ngen_q, ngen_d;
    logic [PER_W-1:0] per_q, per_d;
    logic [GEN_W-1:0] gen_q, gen_d;
    logic [1:0]       row_q, row_d;
    logic [1:0]       col_q, col_d;
    logic             val_q, val_d;
    logic             we_q, we_d;
    logic             run_q, run_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [3:0]       nxt_idx;

    // State and output registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            div_q   <= '0;
            pat_q   <= '0;
            ngen_q  <= '0;
            per_q   <= PER_W'(1);
            gen_q   <= '0;
            row_q   <= '0;
            col_q   <= '0;
            val_q   <= 1'b0;
            we_q    <= 1'b0;
            run_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            div_q   <= div_d;
            pat_q   <= pat_d;
            ngen_q  <= ngen_d;
            per_q   <= per_d;
            gen_q   <= gen_d;
            row_q   <= row_d;
            col_q   <= col_d;
            val_q   <= val_d;
            we_q    <= we_d;
            run_q   <= run_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next state; output registers are loaded with the value for the coming
    // cycle so the write for idx lands while state_q==LOAD and idx_q==idx.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        div_d   = div_q;
        pat_d   = pat_q;
        ngen_d  = ngen_q;
        per_d   = per_q;
        gen_d   = gen_q;
        row_d   = row_q;
        col_d   = col_q;
        val_d   = val_q;
        we_d    = 1'b0;
        run_d   = 1'b0;
        done_d  = 1'b0;
        nxt_idx = idx_q + 4'd1;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    pat_d   = pattern;
                    ngen_d  = num_gens;
                    per_d   = (period == '0) ? PER_W'(1) : period;
                    gen_d   = '0;
                    idx_d   = '0;
                    we_d    = 1'b1;
                    row_d   = 2'd0;
                    col_d   = 2'd0;
                    val_d   = pattern[0];
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else if (idx_q == 4'd15) begin
                    div_d   = '0;
                    state_d = S_RUN;
                end else begin
                    idx_d = nxt_idx;
                    we_d  = 1'b1;
                    row_d = nxt_idx[1:0];
                    col_d = nxt_idx[3:2];
                    val_d = pat_q[nxt_idx];
                end
            end
            S_RUN: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else if (div_q == per_q - PER_W'(1)) begin
                    div_d = '0;
                    run_d = 1'b1;
                    gen_d = gen_q + GEN_W'(1);
                    // num_gens==0 runs forever; gen_count wraps naturally
                    if (ngen_q != '0 && gen_d == ngen_q) begin
                        state_d = S_DONE;
                    end
                end else begin
                    div_d = div_q + PER_W'(1);
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_LOAD) || (state_d == S_RUN);
    end

    assign row       = row_q;
    assign col       = col_q;
    assign val       = val_q;
    assign write_enb = we_q;
    assign run       = run_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign gen_count = gen_q;

endmodule

// File: tb/tb_life_ctrl_4x4.sv
// Self-checking bench for life_ctrl_4x4: directed scenarios plus random
// start/stop/reset traffic, all compared each cycle against a timeline model
// that derives expected outputs from the cycle offset since the last start.
module tb_life_ctrl_4x4;

    logic        clk;
    logic        reset;
    logic        start;
    logic        stop;
    logic [15:0] pattern;
    logic [7:0]  num_gens;
    logic [15:0] period;
    logic [1:0]  row;
    logic [1:0]  col;
    logic        val;
    logic        write_enb;
    logic        run;
    logic        busy;
    logic        done;
    logic [7:0]  gen_count;

    life_ctrl_4x4 #(.GEN_W(8), .PER_W(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .stop      (stop),
        .pattern   (pattern),
        .num_gens  (num_gens),
        .period    (period),
        .row       (row),
        .col       (col),
        .val       (val),
        .write_enb (write_enb),
        .run       (run),
        .busy      (busy),
        .done      (done),
        .gen_count (gen_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Timeline model: m_k counts cycles since the start edge (k=0 is the
    // first write cycle). Expected outputs follow from k arithmetically.
    bit          m_act;
    int          m_k;
    logic [15:0] m_pat;
    int          m_ng;
    int          m_per;
    logic [1:0]  e_row, e_col;
    logic        e_val, e_we, e_run, e_busy, e_done;
    logic [7:0]  e_gen;
    int          we_cnt, run_cnt, done_cnt;

    function automatic bit m_busy(input int k);
        return (k <= 15) || (m_ng == 0) || (k < 16 + m_ng * m_per);
    endfunction

    task automatic model_edge();
        bit idle;
        int j;
        if (!reset) begin
            m_act = 0; m_k = 0;
            e_row = '0; e_col = '0; e_val = 1'b0; e_gen = '0;
        end else begin
            idle = !m_act || (m_ng != 0 && m_k >= 16 + m_ng * m_per + 1);
            if (idle) begin
                if (start) begin
                    m_pat = pattern;
                    m_ng  = int'(num_gens);
                    m_per = (period == 16'd0) ? 1 : int'(period);
                    m_act = 1;
                    m_k   = 0;
                end else begin
                    m_act = 0;
                end
            end else if (stop && m_busy(m_k)) begin
                m_act = 0;
            end else begin
                m_k++;
            end
        end
        e_we = 1'b0; e_run = 1'b0; e_busy = 1'b0; e_done = 1'b0;
        if (m_act) begin
            if (m_k <= 15) begin
                e_we  = 1'b1;
                e_row = m_k[1:0];
                e_col = m_k[3:2];
                e_val = m_pat[m_k[3:0]];
                e_gen = '0;
            end else begin
                j     = (m_k - 16) / m_per;
                e_run = (m_k > 16) && ((m_k - 16) % m_per == 0) && (m_ng == 0 || j <= m_ng);
                e_gen = 8'((m_ng != 0 && j > m_ng) ? m_ng : j);
            end
            e_busy = m_busy(m_k);
            e_done = (m_ng != 0) && (m_k == 16 + m_ng * m_per + 1);
        end
    endtask

    // Called at a negedge: drive inputs, advance model, check after the next posedge.
    task automatic tick(input logic r, input logic s, input logic p);
        reset = r; start = s; stop = p;
        model_edge();
        @(negedge clk);
        chk("row", 32'(row), 32'(e_row));
        chk("col", 32'(col), 32'(e_col));
        chk("val", 32'(val), 32'(e_val));
        chk("write_enb", 32'(write_enb), 32'(e_we));
        chk("run", 32'(run), 32'(e_run));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("done", 32'(done), 32'(e_done));
        chk("gen_count", 32'(gen_count), 32'(e_gen));
        if (write_enb) we_cnt++;
        if (run) run_cnt++;
        if (done) done_cnt++;
    endtask

    initial begin
        m_act = 0; m_k = 0; m_pat = '0; m_ng = 0; m_per = 1;
        we_cnt = 0; run_cnt = 0; done_cnt = 0;
        reset = 1'b0; start = 1'b0; stop = 1'b0;
        pattern = '0; num_gens = '0; period = '0;

        // Reset held two cycles, start during reset ignored
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0);
        tick(1'b1, 1'b0, 1'b0);

        // Block still life: 16 writes, 3 pulses every 4 clocks, one done
        pattern = 16'h0660; num_gens = 8'd3; period = 16'd4;
        we_cnt = 0; run_cnt = 0; done_cnt = 0;
        tick(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 40; i++) tick(1'b1, 1'b0, 1'b0);
        chk("block_writes", 32'(we_cnt), 32'd16);
        chk("block_runs", 32'(run_cnt), 32'd3);
        chk("block_done", 32'(done_cnt), 32'd1);
        chk("block_gen", 32'(gen_count), 32'd3);

        // Blinker, period 0 -> back-to-back pulses; inputs changed after start
        pattern = 16'h0070; num_gens = 8'd2; period = 16'd0;
        run_cnt = 0;
        tick(1'b1, 1'b1, 1'b0);
        pattern = 16'hffff; num_gens = 8'd9; period = 16'd7;
        for (int i = 0; i < 25; i++) tick(1'b1, 1'b0, 1'b0);
        chk("blink_runs", 32'(run_cnt), 32'd2);

        // Free run, stop after the fifth pulse
        pattern = 16'h1234; num_gens = 8'd0; period = 16'd2;
        done_cnt = 0;
        tick(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 26; i++) tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, 1'b0);
        chk("free_gen", 32'(gen_count), 32'd5);
        chk("free_done", 32'(done_cnt), 32'd0);

        // Stop at load idx 7, then reload with new inputs
        pattern = 16'hbeef; num_gens = 8'd1; period = 16'd1;
        we_cnt = 0;
        tick(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b1);
        tick(1'b1, 1'b0, 1'b0);
        chk("partial_writes", 32'(we_cnt), 32'd8);
        pattern = 16'h5a5a; we_cnt = 0;
        tick(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 22; i++) tick(1'b1, 1'b0, 1'b0);
        chk("reload_writes", 32'(we_cnt), 32'd16);

        // Start during RUN ignored; reset mid-RUN clears everything
        pattern = 16'h0f0f; num_gens = 8'd0; period = 16'd3;
        tick(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 25; i++) tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        chk("rst_gen", 32'(gen_count), 32'd0);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            pattern  = 16'($urandom);
            num_gens = 8'($urandom_range(0, 4));
            period   = 16'($urandom_range(0, 5));
            tick(($urandom_range(0, 199) != 0),
                 ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 59) == 0));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/life_ctrl_4x4.md
Name: life_ctrl_4x4

Overview:
- Sequencer that sits directly upstream of the 4x4 life array.
- Drives the array's row, col, val, write_enb and run inputs.
- On start, writes a 16-bit seed pattern into the array one cell per clock, then issues run pulses at a programmable period for a programmable number of generations.
- Signals completion to the host and reports the generation count.

Parameters:
- GEN_W, 8: width of the generation count and the num_gens request.
- PER_W, 16: width of the run-pulse period request.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset; sampled on the rising edge of clk.
- start  in  1  begin load-then-run; honoured only in IDLE.
- stop  in  1  abort LOAD/RUN; return to IDLE; no done pulse.
- pattern  in  16  seed; bit i goes to cell col=i[3:2], row=i[1:0] (matches the array's alive[i]).
- num_gens  in  GEN_W  generations to run; 0 = run until stop.
- period  in  PER_W  clocks between run pulses; 0 treated as 1.
- row  out  2  array row address.
- col  out  2  array column address.
- val  out  1  cell value to write.
- write_enb  out  1  array write strobe.
- run  out  1  one-cycle generation-advance pulse to the array.
- busy  out  1  high in LOAD and RUN.
- done  out  1  one-cycle pulse when num_gens generations have completed.
- gen_count  out  GEN_W  run pulses issued since the last start; holds after completion.

Behaviour:
- Reset (reset==0 at a clock edge):
  - state=IDLE; row=col=0; val=0; write_enb=0; run=0; busy=0; done=0; gen_count=0; internal index and divider cleared.
  - Reset overrides start and stop, and applies mid-LOAD and mid-RUN.
- All outputs are registered; no combinational paths from inputs to outputs.
- States: IDLE, LOAD, RUN, DONE.
- IDLE:
  - Outputs idle low.
  - On start==1: capture pattern, num_gens and period (period 0 -> 1) into shadow registers; clear gen_count; go to LOAD with idx=0.
  - Later changes to the inputs have no effect until the next start.
- LOAD:
  - Each cycle: write_enb=1, col=idx[3:2], row=idx[1:0], val=pat_shadow[idx].
  - Writes happen on exactly 16 consecutive cycles, idx 0..15, first write one cycle after start is sampled.
  - After idx 15: write_enb=0 and go to RUN with divider=0.
- RUN:
  - Divider counts 0..period-1 and wraps.
  - run=1 for exactly one cycle each time the divider equals period-1; the first pulse comes period cycles after RUN entry.
  - period==1 gives a run pulse every cycle.
  - gen_count increments in the same cycle run is asserted.
  - gen_count wraps modulo 2^GEN_W when num_gens==0.
  - write_enb=0 throughout.
  - Once the pulse bringing gen_count to num_gens (num_gens!=0) has been issued, go to DONE; no further run pulses.
- DONE:
  - done=1 for one cycle, then IDLE.
  - gen_count holds its final value.
- busy is high in LOAD and RUN only; low in IDLE and DONE.
- stop:
  - Sampled in LOAD or RUN: next state IDLE; write_enb and run are 0 from the next cycle; done is not pulsed; gen_count holds.
  - stop in IDLE or DONE is ignored.
  - stop and start together in IDLE: start wins (stop is ignored in IDLE).
- start outside IDLE is ignored; no restart or requeue.
- A partially loaded array after stop/reset is acceptable; the host restarts to reload.
- row/col/val hold their last values outside LOAD (don't-care to the array while write_enb=0); after reset they are 0.

Test Plan:
- Reset, then hold reset=0 two cycles -> all outputs 0, state IDLE; start during reset is ignored.
- pattern=16'h0660, num_gens=3, period=4, start pulse:
  - write_enb high on exactly 16 cycles, idx 0..15, val=1 at idx 5,6,9,10.
  - Then run pulses at 4-cycle spacing, gen_count 1,2,3.
  - done pulses 1 cycle after the 3rd pulse; busy low afterwards.
  - Array alive stays 16'h0660 (block still life).
- pattern=16'h0070 (blinker), period=0, num_gens=2 -> run pulses on 2 consecutive cycles; after done, array alive==16'h0070.
- num_gens=0, period=2: let 5 pulses issue, assert stop -> no further run, done never pulses, gen_count=5, busy=0.
- stop asserted at LOAD idx 7 -> exactly 8 writes occurred, next cycle write_enb=0, IDLE; a second start re-captures new inputs and loads 16 cells.
- start re-asserted during RUN and reset=0 mid-RUN -> start ignored; reset clears gen_count to 0 and all outputs, state IDLE.
